// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states
// and the datapath select codes.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_REXE    = 4'd7,
        ST_RWB     = 4'd8,
        ST_BEQ     = 4'd9,
        ST_ADDIEXE = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_JMP     = 4'd12,
        ST_HALT    = 4'd13
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for opcodes the controller knows how to sequence.
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_J) || (op == OP_HALT);
    endfunction

    // Last state of each instruction that counts as retired.
    function automatic logic is_retiring(input state_t s);
        return (s == ST_MEMWB) || (s == ST_MEMWR) || (s == ST_RWB) ||
               (s == ST_ADDIWB) || (s == ST_BEQ) || (s == ST_JMP);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps the controller state onto datapath strobes and
// selects. Anything not driven for a state stays 0.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [3:0] i_state,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_busy,
    output logic       o_halted
);

    logic [3:0] w_state;
    assign w_state = i_state;

    // Per-state control word, zero by default.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_B;
        o_alu_op        = ALU_ADD;
        o_pc_src        = PCSRC_ALU;
        o_busy          = 1'b1;
        o_halted        = 1'b0;
        case (w_state)
            ST_IDLE: begin
                o_busy = 1'b0;
            end
            ST_FETCH: begin
                o_mem_read  = 1'b1;
                o_ir_write  = 1'b1;
                o_pc_write  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_alu_op    = ALU_ADD;
                o_pc_src    = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target goes into ALUOut.
                o_alu_src_b = SRCB_IMM_SH2;
                o_alu_op    = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEXE: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            ST_MEMWR: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            ST_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            ST_REXE: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            ST_ADDIWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b0;
            end
            ST_BEQ: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALU_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_src        = PCSRC_ALUOUT;
            end
            ST_JMP: begin
                o_pc_write = 1'b1;
                o_pc_src   = PCSRC_JUMP;
            end
            ST_HALT: begin
                o_busy   = 1'b0;
                o_halted = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with run/halt handshake, sticky illegal-opcode
// flag and saturating retired-instruction counter.
//
//  state    | meaning
//  ---------+---------------------------------------------------
//  IDLE     | out of reset, waiting for start
//  FETCH    | read instruction into IR, PC <= PC + 4
//  DECODE   | read registers, branch target into ALUOut
//  MEMADR   | lw/sw effective address
//  MEMRD    | lw data read
//  MEMWB    | lw register write-back
//  MEMWR    | sw data write
//  REXE     | R-type ALU operation
//  RWB      | R-type register write-back (rd)
//  BEQ      | compare, conditional PC load from ALUOut
//  ADDIEXE  | addi ALU operation
//  ADDIWB   | addi register write-back (rt)
//  JMP      | PC <= jump target
//  HALT     | program finished or illegal opcode; result stable
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pc_en,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;
    logic             w_restart;
    logic             w_illegal;

    assign w_restart = (r_state == ST_HALT) && start;
    assign w_illegal = (r_state == ST_DECODE) && !is_legal_op(opcode);

    // State register; reset drops straight to IDLE, even mid-instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    w_next_state = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:   w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_R:         w_next_state = ST_REXE;
                    OP_BEQ:       w_next_state = ST_BEQ;
                    OP_ADDI:      w_next_state = ST_ADDIEXE;
                    OP_J:         w_next_state = ST_JMP;
                    default:      w_next_state = ST_HALT;
                endcase
            end
            // IR is frozen after FETCH, so the opcode still selects load vs store.
            ST_MEMADR:  w_next_state = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   w_next_state = ST_MEMWB;
            ST_MEMWB:   w_next_state = ST_FETCH;
            ST_MEMWR:   w_next_state = ST_FETCH;
            ST_REXE:    w_next_state = ST_RWB;
            ST_RWB:     w_next_state = ST_FETCH;
            ST_ADDIEXE: w_next_state = ST_ADDIWB;
            ST_ADDIWB:  w_next_state = ST_FETCH;
            ST_BEQ:     w_next_state = ST_FETCH;
            ST_JMP:     w_next_state = ST_FETCH;
            ST_HALT:    w_next_state = start ? ST_FETCH : ST_HALT;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Sticky illegal-opcode flag, cleared when the harness restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_restart) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_restart) begin
            r_retired <= '0;
        end else if (is_retiring(r_state) && (r_retired != {CNT_W{1'b1}})) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Moore output decode.
    mips_ctrl_decode u_decode (
        .i_state         (r_state),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_iord          (iord),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_alu_op        (alu_op),
        .o_pc_src        (pc_src),
        .o_busy          (busy),
        .o_halted        (halted)
    );

    // Only combinational path: branch outcome straight into the PC enable.
    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign err     = r_err;
    assign retired = r_retired;

endmodule
